// File: rtl/exc_ctrl_if.sv
// Exception controller bundle: pipeline-stage exception requests in, COP0
// exception record and PC redirect out.
interface exc_ctrl_if;
    logic        MEM_ADEL_IN;
    logic        MEM_ADES_IN;
    logic [31:0] MEM_ADDR_IN;
    logic [31:0] MEM_PC_IN;
    logic        MEM_BD_IN;
    logic        EX_OVF_IN;
    logic [31:0] EX_PC_IN;
    logic        EX_BD_IN;
    logic [3:0]  ID_EXC_IN;
    logic [1:0]  ID_CPU_NUM_IN;
    logic [31:0] ID_PC_IN;
    logic        ID_BD_IN;
    logic        IF_ADEL_IN;
    logic [31:0] IF_PC_IN;
    logic        IF_BD_IN;
    logic        COP0_INT_IN;
    logic [31:0] CORE_EXC_VECTOR_IN;

    logic        CORE_EXC_EN_OUT;
    logic [1:0]  CORE_EXC_CE_OUT;
    logic [4:0]  CORE_EXC_CODE_OUT;
    logic        CORE_EXC_BD_OUT;
    logic [31:0] CORE_EXC_EPC_OUT;
    logic [31:0] CORE_EXC_BADVA_OUT;
    logic        EXC_DETECT_OUT;
    logic        FLUSH_OUT;
    logic        PC_LOAD_OUT;
    logic [31:0] PC_LOAD_ADDR_OUT;

    modport master (
        output MEM_ADEL_IN, MEM_ADES_IN, MEM_ADDR_IN, MEM_PC_IN, MEM_BD_IN,
               EX_OVF_IN, EX_PC_IN, EX_BD_IN,
               ID_EXC_IN, ID_CPU_NUM_IN, ID_PC_IN, ID_BD_IN,
               IF_ADEL_IN, IF_PC_IN, IF_BD_IN,
               COP0_INT_IN, CORE_EXC_VECTOR_IN,
        input  CORE_EXC_EN_OUT, CORE_EXC_CE_OUT, CORE_EXC_CODE_OUT,
               CORE_EXC_BD_OUT, CORE_EXC_EPC_OUT, CORE_EXC_BADVA_OUT,
               EXC_DETECT_OUT, FLUSH_OUT, PC_LOAD_OUT, PC_LOAD_ADDR_OUT
    );

    modport slave (
        input  MEM_ADEL_IN, MEM_ADES_IN, MEM_ADDR_IN, MEM_PC_IN, MEM_BD_IN,
               EX_OVF_IN, EX_PC_IN, EX_BD_IN,
               ID_EXC_IN, ID_CPU_NUM_IN, ID_PC_IN, ID_BD_IN,
               IF_ADEL_IN, IF_PC_IN, IF_BD_IN,
               COP0_INT_IN, CORE_EXC_VECTOR_IN,
        output CORE_EXC_EN_OUT, CORE_EXC_CE_OUT, CORE_EXC_CODE_OUT,
               CORE_EXC_BD_OUT, CORE_EXC_EPC_OUT, CORE_EXC_BADVA_OUT,
               EXC_DETECT_OUT, FLUSH_OUT, PC_LOAD_OUT, PC_LOAD_ADDR_OUT
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception controller: prioritises stage requests, records the winner for
// COP0, flushes the pipe and redirects the PC to the COP0 vector.
module exc_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'hbfc0_0000
) (
    input  logic      CLK,
    input  logic      RST_SYNC,
    exc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXC, VEC} state_t;

    typedef struct packed {
        logic [4:0]  code;
        logic [1:0]  ce;
        logic        bd;
        logic [31:0] epc;
        logic [31:0] badva;
    } exc_rec_t;

    function automatic exc_rec_t mk_rec(input logic [4:0] code, input logic [1:0] ce,
                                        input logic bd, input logic [31:0] epc,
                                        input logic [31:0] badva);
        exc_rec_t r;
        r.code  = code;
        r.ce    = ce;
        r.bd    = bd;
        r.epc   = epc;
        r.badva = badva;
        return r;
    endfunction

    state_t      state;
    exc_rec_t    sel;
    exc_rec_t    rec;
    logic        req_any;
    logic        exc_en;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc_addr;

    // Oldest stage wins; within ID the order is CpU, RI, Bp, Sys.
    always_comb begin
        sel     = '0;
        req_any = 1'b1;
        if (bus.MEM_ADEL_IN)
            sel = mk_rec(5'd4, 2'b00, bus.MEM_BD_IN, bus.MEM_PC_IN, bus.MEM_ADDR_IN);
        else if (bus.MEM_ADES_IN)
            sel = mk_rec(5'd5, 2'b00, bus.MEM_BD_IN, bus.MEM_PC_IN, bus.MEM_ADDR_IN);
        else if (bus.EX_OVF_IN)
            sel = mk_rec(5'd12, 2'b00, bus.EX_BD_IN, bus.EX_PC_IN, 32'h0);
        else if (bus.ID_EXC_IN[3])
            sel = mk_rec(5'd11, bus.ID_CPU_NUM_IN, bus.ID_BD_IN, bus.ID_PC_IN, 32'h0);
        else if (bus.ID_EXC_IN[2])
            sel = mk_rec(5'd10, 2'b00, bus.ID_BD_IN, bus.ID_PC_IN, 32'h0);
        else if (bus.ID_EXC_IN[1])
            sel = mk_rec(5'd9, 2'b00, bus.ID_BD_IN, bus.ID_PC_IN, 32'h0);
        else if (bus.ID_EXC_IN[0])
            sel = mk_rec(5'd8, 2'b00, bus.ID_BD_IN, bus.ID_PC_IN, 32'h0);
        else if (bus.IF_ADEL_IN)
            sel = mk_rec(5'd4, 2'b00, bus.IF_BD_IN, bus.IF_PC_IN, bus.IF_PC_IN);
        else if (bus.COP0_INT_IN)
            // Interrupt is taken on the instruction currently in ID.
            sel = mk_rec(5'd0, 2'b00, bus.ID_BD_IN, bus.ID_PC_IN, 32'h0);
        else
            req_any = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST_SYNC) begin
        if (RST_SYNC) begin
            state   <= IDLE;
            exc_en  <= 1'b0;
            flush   <= 1'b0;
            pc_load <= 1'b0;
            rec     <= '0;
            pc_addr <= RESET_VEC;
        end else begin
            case (state)
                IDLE: begin
                    exc_en  <= 1'b0;
                    pc_load <= 1'b0;
                    flush   <= 1'b0;
                    if (req_any) begin
                        state  <= EXC;
                        exc_en <= 1'b1;
                        flush  <= 1'b1;
                        rec    <= sel;
                    end
                end
                EXC: begin
                    state   <= VEC;
                    exc_en  <= 1'b0;
                    flush   <= 1'b1;
                    pc_load <= 1'b1;
                    pc_addr <= bus.CORE_EXC_VECTOR_IN;
                end
                VEC: begin
                    state   <= IDLE;
                    exc_en  <= 1'b0;
                    flush   <= 1'b0;
                    pc_load <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    exc_en  <= 1'b0;
                    flush   <= 1'b0;
                    pc_load <= 1'b0;
                end
            endcase
        end
    end

    assign bus.EXC_DETECT_OUT     = (state == IDLE) && req_any;
    assign bus.CORE_EXC_EN_OUT    = exc_en;
    assign bus.CORE_EXC_CE_OUT    = rec.ce;
    assign bus.CORE_EXC_CODE_OUT  = rec.code;
    assign bus.CORE_EXC_BD_OUT    = rec.bd;
    assign bus.CORE_EXC_EPC_OUT   = rec.epc;
    assign bus.CORE_EXC_BADVA_OUT = rec.badva;
    assign bus.FLUSH_OUT          = flush;
    assign bus.PC_LOAD_OUT        = pc_load;
    assign bus.PC_LOAD_ADDR_OUT   = pc_addr;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: behavioural model checked every cycle plus
// literal expectations taken from worked examples.
module tb_exc_ctrl;
    localparam logic [31:0] RVEC = 32'hbfc0_0000;

    logic CLK = 1'b0;
    logic RST_SYNC = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    exc_ctrl_if bus();
    exc_ctrl #(.RESET_VEC(RVEC)) dut (.CLK(CLK), .RST_SYNC(RST_SYNC), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          m_left;            // cycles left in the current exception sequence
    logic        m_en, m_flush, m_pcl, m_bd;
    logic [1:0]  m_ce;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badva, m_addr;

    function automatic int winner();
        logic req[9];
        req = '{bus.MEM_ADEL_IN, bus.MEM_ADES_IN, bus.EX_OVF_IN, bus.ID_EXC_IN[3],
                bus.ID_EXC_IN[2], bus.ID_EXC_IN[1], bus.ID_EXC_IN[0], bus.IF_ADEL_IN,
                bus.COP0_INT_IN};
        for (int i = 0; i < 9; i++) if (req[i]) return i;
        return -1;
    endfunction

    always @(posedge CLK or posedge RST_SYNC) begin
        int w;
        int codes[9];
        codes = '{4, 5, 12, 11, 10, 9, 8, 4, 0};
        if (RST_SYNC) begin
            m_left = 0; m_en = 0; m_flush = 0; m_pcl = 0;
            m_code = 0; m_ce = 0; m_bd = 0; m_epc = 0; m_badva = 0; m_addr = RVEC;
        end else if (m_left == 2) begin
            m_left = 1; m_en = 0; m_pcl = 1; m_flush = 1; m_addr = bus.CORE_EXC_VECTOR_IN;
        end else if (m_left == 1) begin
            m_left = 0; m_en = 0; m_pcl = 0; m_flush = 0;
        end else begin
            w = winner();
            m_en = 0; m_pcl = 0; m_flush = 0;
            if (w >= 0) begin
                m_left = 2; m_en = 1; m_flush = 1;
                m_code = 5'(codes[w]);
                m_ce = (w == 3) ? bus.ID_CPU_NUM_IN : 2'b00;
                if (w <= 1) begin
                    m_epc = bus.MEM_PC_IN; m_bd = bus.MEM_BD_IN; m_badva = bus.MEM_ADDR_IN;
                end else if (w == 2) begin
                    m_epc = bus.EX_PC_IN; m_bd = bus.EX_BD_IN; m_badva = 0;
                end else if (w == 7) begin
                    m_epc = bus.IF_PC_IN; m_bd = bus.IF_BD_IN; m_badva = bus.IF_PC_IN;
                end else begin
                    m_epc = bus.ID_PC_IN; m_bd = bus.ID_BD_IN; m_badva = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("detect", 32'(bus.EXC_DETECT_OUT), 32'((m_left == 0) && !RST_SYNC && winner() >= 0));
        chk("exc_en", 32'(bus.CORE_EXC_EN_OUT), 32'(m_en));
        chk("flush",  32'(bus.FLUSH_OUT), 32'(m_flush));
        chk("pc_load", 32'(bus.PC_LOAD_OUT), 32'(m_pcl));
        chk("pc_addr", bus.PC_LOAD_ADDR_OUT, m_addr);
        chk("code",  32'(bus.CORE_EXC_CODE_OUT), 32'(m_code));
        chk("ce",    32'(bus.CORE_EXC_CE_OUT), 32'(m_ce));
        chk("bd",    32'(bus.CORE_EXC_BD_OUT), 32'(m_bd));
        chk("epc",   bus.CORE_EXC_EPC_OUT, m_epc);
        chk("badva", bus.CORE_EXC_BADVA_OUT, m_badva);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic clr();
        bus.MEM_ADEL_IN = 0; bus.MEM_ADES_IN = 0; bus.EX_OVF_IN = 0;
        bus.ID_EXC_IN = 0; bus.IF_ADEL_IN = 0; bus.COP0_INT_IN = 0;
    endtask

    initial begin
        logic [8:0] pats[6];
        clr();
        bus.MEM_ADDR_IN = 32'h0000_2001; bus.MEM_PC_IN = 32'h8000_0300; bus.MEM_BD_IN = 0;
        bus.EX_PC_IN = 32'h8000_0100; bus.EX_BD_IN = 0;
        bus.ID_CPU_NUM_IN = 0; bus.ID_PC_IN = 32'h8000_00fc; bus.ID_BD_IN = 0;
        bus.IF_PC_IN = 32'h8000_0f02; bus.IF_BD_IN = 1;
        bus.CORE_EXC_VECTOR_IN = 32'h8000_0080;

        repeat (2) cyc();
        @(negedge CLK);
        chk("rst_addr", bus.PC_LOAD_ADDR_OUT, RVEC);
        chk("rst_en", 32'(bus.CORE_EXC_EN_OUT), 0);
        cyc(); RST_SYNC = 0;

        // overflow in EX: strobe next cycle, PC load the cycle after
        cyc(); bus.EX_OVF_IN = 1;
        @(negedge CLK); chk("ovf_detect", 32'(bus.EXC_DETECT_OUT), 1);
        cyc(); clr();
        @(negedge CLK);
        chk("ovf_en", 32'(bus.CORE_EXC_EN_OUT), 1);
        chk("ovf_code", 32'(bus.CORE_EXC_CODE_OUT), 12);
        chk("ovf_epc", bus.CORE_EXC_EPC_OUT, 32'h8000_0100);
        cyc(); @(negedge CLK);
        chk("ovf_pcl", 32'(bus.PC_LOAD_OUT), 1);
        chk("ovf_addr", bus.PC_LOAD_ADDR_OUT, 32'h8000_0080);
        repeat (2) cyc();

        // simultaneous store error, syscall and interrupt
        bus.MEM_ADDR_IN = 32'h0000_1003; bus.CORE_EXC_VECTOR_IN = 32'h8000_0180;
        bus.MEM_ADES_IN = 1; bus.ID_EXC_IN = 4'b0001; bus.COP0_INT_IN = 1;
        cyc(); clr();
        @(negedge CLK);
        chk("ades_code", 32'(bus.CORE_EXC_CODE_OUT), 5);
        chk("ades_badva", bus.CORE_EXC_BADVA_OUT, 32'h0000_1003);
        cyc(); @(negedge CLK); chk("ades_single", 32'(bus.CORE_EXC_EN_OUT), 0);
        repeat (2) cyc();

        // coprocessor unusable in a delay slot
        bus.ID_EXC_IN = 4'b1000; bus.ID_CPU_NUM_IN = 2'd2; bus.ID_BD_IN = 1;
        bus.ID_PC_IN = 32'hbfc0_0204;
        cyc(); clr();
        @(negedge CLK);
        chk("cpu_code", 32'(bus.CORE_EXC_CODE_OUT), 11);
        chk("cpu_ce", 32'(bus.CORE_EXC_CE_OUT), 2);
        chk("cpu_bd", 32'(bus.CORE_EXC_BD_OUT), 1);
        chk("cpu_epc", bus.CORE_EXC_EPC_OUT, 32'hbfc0_0204);
        repeat (3) cyc();
        bus.ID_BD_IN = 0; bus.ID_CPU_NUM_IN = 2'd1;

        // interrupt held high; fetch error raised only while busy
        bus.COP0_INT_IN = 1;
        cyc(); bus.IF_ADEL_IN = 1;
        @(negedge CLK);
        chk("int_en1", 32'(bus.CORE_EXC_EN_OUT), 1);
        chk("int_code1", 32'(bus.CORE_EXC_CODE_OUT), 0);
        cyc(); @(negedge CLK);
        chk("int_vec_detect", 32'(bus.EXC_DETECT_OUT), 0);
        cyc(); bus.IF_ADEL_IN = 0;
        @(negedge CLK);
        chk("int_gap_en", 32'(bus.CORE_EXC_EN_OUT), 0);
        chk("int_redetect", 32'(bus.EXC_DETECT_OUT), 1);
        cyc(); @(negedge CLK);
        chk("int_en2", 32'(bus.CORE_EXC_EN_OUT), 1);
        bus.COP0_INT_IN = 0;
        repeat (3) cyc();

        // priority sweep {MEM_ADEL,MEM_ADES,OVF,CpU,RI,Bp,Sys,IF_ADEL,INT}
        pats = '{9'b000000011, 9'b000010010, 9'b000101000, 9'b001011111,
                 9'b100000010, 9'b000001100};
        foreach (pats[k]) begin
            {bus.MEM_ADEL_IN, bus.MEM_ADES_IN, bus.EX_OVF_IN, bus.ID_EXC_IN,
             bus.IF_ADEL_IN, bus.COP0_INT_IN} = pats[k];
            bus.MEM_ADDR_IN = 32'h1000_0000 + 32'(k);
            cyc(); clr();
            repeat (3) cyc();
        end

        // reset in the middle of EXC aborts the sequence
        bus.ID_EXC_IN = 4'b0100;
        cyc(); clr();
        #2 RST_SYNC = 1;
        #1;
        chk("abort_en", 32'(bus.CORE_EXC_EN_OUT), 0);
        chk("abort_flush", 32'(bus.FLUSH_OUT), 0);
        chk("abort_code", 32'(bus.CORE_EXC_CODE_OUT), 0);
        chk("abort_addr", bus.PC_LOAD_ADDR_OUT, RVEC);
        cyc(); RST_SYNC = 0;
        repeat (4) begin
            @(negedge CLK); chk("abort_no_pcl", 32'(bus.PC_LOAD_OUT), 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
